// File: rtl/simt_reconv_stack_pkg.sv
// Shared types and sizing constants for the SIMT reconvergence stack.
package simt_reconv_stack_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int SIMT_MASK_W      = 32;
  localparam int SIMT_NUM_WARPS   = 8;
  localparam int SIMT_STACK_DEPTH = 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  reconvergence_pc;
    logic [SIMT_MASK_W-1:0] active_mask;
    logic [SIMT_MASK_W-1:0] taken_mask;
  } simt_stack_entry_t;

endpackage

// File: rtl/simt_reconv_stack_if.sv
// Divergence push/pop interface between the execute stage (master) and the reconvergence stack (slave).
interface simt_reconv_stack_if
  import simt_reconv_stack_pkg::*;
#(
  parameter int NUM_WARPS   = SIMT_NUM_WARPS,
  parameter int STACK_DEPTH = SIMT_STACK_DEPTH
) ();

  localparam int WW = $clog2(NUM_WARPS);
  localparam int DW = $clog2(STACK_DEPTH) + 1;

  logic [WW-1:0]         warp_id;
  logic                  pc_valid;
  logic [ADDR_WIDTH-1:0] current_pc;
  logic                  push;
  simt_stack_entry_t     push_entry;
  logic                  pop;
  logic                  flush_warp;
  logic [WW-1:0]         flush_warp_id;
  simt_stack_entry_t     top_entry;
  logic                  at_reconvergence;
  logic                  stack_empty;
  logic                  stack_full;
  logic [DW-1:0]         stack_depth;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output warp_id, pc_valid, current_pc, push, push_entry, pop, flush_warp, flush_warp_id,
    input  top_entry, at_reconvergence, stack_empty, stack_full, stack_depth,
           overflow_err, underflow_err
  );

  modport slave (
    input  warp_id, pc_valid, current_pc, push, push_entry, pop, flush_warp, flush_warp_id,
    output top_entry, at_reconvergence, stack_empty, stack_full, stack_depth,
           overflow_err, underflow_err
  );

endinterface

// File: rtl/simt_reconv_stack_bank.sv
// Single-warp divergence stack: entry storage, depth counter and push/pop/flush update.
module simt_stack_bank
  import simt_reconv_stack_pkg::*;
#(
  parameter int STACK_DEPTH = SIMT_STACK_DEPTH,
  localparam int IW = $clog2(STACK_DEPTH),
  localparam int DW = $clog2(STACK_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  simt_stack_entry_t push_entry,
  output simt_stack_entry_t top_entry,
  output logic [DW-1:0]     depth
);

  simt_stack_entry_t mem [STACK_DEPTH];

  logic [DW-1:0] depth_nxt;
  logic [DW-1:0] depth_m1;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;
  logic          wr_en;
  logic          empty;
  logic          full;

  assign empty    = (depth == '0);
  assign full     = (depth == DW'(STACK_DEPTH));
  assign depth_m1 = depth - DW'(1);
  assign top_idx  = depth_m1[IW-1:0];

  // Flush dominates; push+pop on a non-empty stack rewrites the top in place.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = depth[IW-1:0];
    depth_nxt = depth;
    if (flush) begin
      depth_nxt = '0;
    end else if (push && pop && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push && !full) begin
      wr_en     = 1'b1;
      depth_nxt = depth + DW'(1);
    end else if (pop && !push && !empty) begin
      depth_nxt = depth_m1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) depth <= '0;
    else        depth <= depth_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_entry;
  end

  assign top_entry = empty ? '0 : mem[top_idx];

endmodule

// File: rtl/simt_reconv_stack.sv
// Per-warp SIMT reconvergence stack: warp demux, top/status mux, reconvergence compare, sticky errors.
module simt_reconv_stack
  import simt_reconv_stack_pkg::*;
#(
  parameter int NUM_WARPS   = SIMT_NUM_WARPS,
  parameter int STACK_DEPTH = SIMT_STACK_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  simt_reconv_stack_if.slave bus
);

  localparam int WW = $clog2(NUM_WARPS);
  localparam int DW = $clog2(STACK_DEPTH) + 1;

  simt_stack_entry_t tops   [NUM_WARPS];
  logic [DW-1:0]     depths [NUM_WARPS];

  simt_stack_entry_t sel_top;
  logic [DW-1:0]     sel_depth;
  logic              sel_empty;
  logic              sel_full;
  logic              overflow_q;
  logic              underflow_q;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_bank
    simt_stack_bank #(.STACK_DEPTH(STACK_DEPTH)) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (bus.push && (bus.warp_id == WW'(w))),
      .pop        (bus.pop  && (bus.warp_id == WW'(w))),
      .flush      (bus.flush_warp && (bus.flush_warp_id == WW'(w))),
      .push_entry (bus.push_entry),
      .top_entry  (tops[w]),
      .depth      (depths[w])
    );
  end

  assign sel_top   = tops[bus.warp_id];
  assign sel_depth = depths[bus.warp_id];
  assign sel_empty = (sel_depth == '0);
  assign sel_full  = (sel_depth == DW'(STACK_DEPTH));

  // Push+pop on a full stack is a top replace, so it is not an overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push && !bus.pop && sel_full) overflow_q  <= 1'b1;
      if (bus.pop && sel_empty)             underflow_q <= 1'b1;
    end
  end

  assign bus.top_entry        = sel_top;
  assign bus.stack_depth      = sel_depth;
  assign bus.stack_empty      = sel_empty;
  assign bus.stack_full       = sel_full;
  assign bus.overflow_err     = overflow_q;
  assign bus.underflow_err    = underflow_q;
  assign bus.at_reconvergence = bus.pc_valid && !sel_empty &&
                                (bus.current_pc == sel_top.reconvergence_pc);

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Directed bench for simt_reconv_stack: push/pop, overflow/underflow, replace, flush, async reset.
module tb_simt_reconv_stack;
  import simt_reconv_stack_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  simt_reconv_stack_if #(.NUM_WARPS(8), .STACK_DEPTH(8)) ifc ();

  simt_reconv_stack #(.NUM_WARPS(8), .STACK_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic simt_stack_entry_t mk(input logic [31:0] pc, input logic [31:0] am,
                                           input logic [31:0] tm);
    simt_stack_entry_t e;
    e.reconvergence_pc = pc;
    e.active_mask      = am;
    e.taken_mask       = tm;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ifc.push       = 1'b0;
    ifc.pop        = 1'b0;
    ifc.flush_warp = 1'b0;
    #1;
  endtask

  task automatic sel(input int w);
    ifc.warp_id = 3'(w);
    #1;
  endtask

  simt_stack_entry_t e0, ea, eb, ec;
  simt_stack_entry_t w2e [9];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifc.warp_id       = '0;
    ifc.pc_valid      = 1'b0;
    ifc.current_pc    = '0;
    ifc.push          = 1'b0;
    ifc.push_entry    = '0;
    ifc.pop           = 1'b0;
    ifc.flush_warp    = 1'b0;
    ifc.flush_warp_id = '0;
    #2;
    chk("rst_depth", 128'(ifc.stack_depth), 128'(0));
    chk("rst_empty", 128'(ifc.stack_empty), 128'(1));
    chk("rst_full",  128'(ifc.stack_full),  128'(0));
    chk("rst_top",   128'(ifc.top_entry),   128'(0));
    chk("rst_ovf",   128'(ifc.overflow_err),  128'(0));
    chk("rst_unf",   128'(ifc.underflow_err), 128'(0));
    chk("rst_arec",  128'(ifc.at_reconvergence), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Warp 0 single push and reconvergence compare
    e0 = mk(32'h100, 32'hFFFF_FFFF, 32'h0000_FFFF);
    sel(0);
    ifc.push = 1'b1; ifc.push_entry = e0;
    tick();
    chk("w0_top",   128'(ifc.top_entry),   128'(e0));
    chk("w0_depth", 128'(ifc.stack_depth), 128'(1));
    chk("w0_empty", 128'(ifc.stack_empty), 128'(0));
    ifc.pc_valid = 1'b1; ifc.current_pc = 32'h100; #1;
    chk("arec_hit", 128'(ifc.at_reconvergence), 128'(1));
    ifc.pc_valid = 1'b0; #1;
    chk("arec_novalid", 128'(ifc.at_reconvergence), 128'(0));
    ifc.pc_valid = 1'b1; ifc.current_pc = 32'h104; #1;
    chk("arec_otherpc", 128'(ifc.at_reconvergence), 128'(0));
    ifc.pop = 1'b1;
    tick();
    chk("w0_pop_depth", 128'(ifc.stack_depth), 128'(0));
    chk("w0_pop_top",   128'(ifc.top_entry),   128'(0));
    chk("w0_pop_empty", 128'(ifc.stack_empty), 128'(1));
    ifc.current_pc = 32'h0; #1;
    chk("arec_empty", 128'(ifc.at_reconvergence), 128'(0));
    ifc.pc_valid = 1'b0;

    // Warp 2 fill past capacity
    sel(2);
    for (int k = 0; k < 9; k++) begin
      w2e[k] = mk(32'h200 + 32'(4 * k), 32'(k + 1), ~32'(k));
      ifc.push = 1'b1; ifc.push_entry = w2e[k];
      tick();
      if (k == 7) begin
        chk("w2_full8",   128'(ifc.stack_full),   128'(1));
        chk("w2_ovf_pre", 128'(ifc.overflow_err), 128'(0));
      end
    end
    chk("w2_ovf",   128'(ifc.overflow_err), 128'(1));
    chk("w2_depth", 128'(ifc.stack_depth),  128'(8));
    chk("w2_top",   128'(ifc.top_entry),    128'(w2e[7]));

    // Underflow on empty warp 3
    sel(3);
    chk("w3_unf_pre", 128'(ifc.underflow_err), 128'(0));
    ifc.pop = 1'b1;
    tick();
    chk("w3_unf",   128'(ifc.underflow_err), 128'(1));
    chk("w3_depth", 128'(ifc.stack_depth),   128'(0));

    // Warp 1 simultaneous push+pop replaces top
    ea = mk(32'h300, 32'h0000_00FF, 32'h0000_000F);
    eb = mk(32'h340, 32'h0000_00F0, 32'h0000_0030);
    ec = mk(32'h380, 32'h0000_000F, 32'h0000_0003);
    sel(1);
    ifc.push = 1'b1; ifc.push_entry = ea; tick();
    ifc.push = 1'b1; ifc.push_entry = eb; tick();
    chk("w1_depth2", 128'(ifc.stack_depth), 128'(2));
    ifc.push = 1'b1; ifc.pop = 1'b1; ifc.push_entry = ec; tick();
    chk("w1_rep_depth", 128'(ifc.stack_depth), 128'(2));
    chk("w1_rep_top",   128'(ifc.top_entry),   128'(ec));
    ifc.pop = 1'b1; tick();
    chk("w1_pop_depth", 128'(ifc.stack_depth), 128'(1));
    chk("w1_pop_top",   128'(ifc.top_entry),   128'(ea));

    // Warp 4 flush vs same-warp push, then flush in parallel with warp 5 push
    sel(4);
    for (int k = 0; k < 3; k++) begin
      ifc.push = 1'b1; ifc.push_entry = mk(32'h400 + 32'(k), 32'h1, 32'h1); tick();
    end
    chk("w4_depth3", 128'(ifc.stack_depth), 128'(3));
    ifc.push = 1'b1; ifc.push_entry = mk(32'h4F0, 32'h1, 32'h0);
    ifc.flush_warp = 1'b1; ifc.flush_warp_id = 3'd4;
    tick();
    chk("w4_flush_depth", 128'(ifc.stack_depth), 128'(0));
    chk("w4_flush_top",   128'(ifc.top_entry),   128'(0));
    ifc.push = 1'b1; ifc.push_entry = mk(32'h410, 32'h1, 32'h1); tick();
    chk("w4_repush", 128'(ifc.stack_depth), 128'(1));
    sel(5);
    ifc.push = 1'b1; ifc.push_entry = mk(32'h500, 32'h3, 32'h1);
    ifc.flush_warp = 1'b1; ifc.flush_warp_id = 3'd4;
    tick();
    chk("w5_depth", 128'(ifc.stack_depth), 128'(1));
    chk("w5_top",   128'(ifc.top_entry),   128'(mk(32'h500, 32'h3, 32'h1)));
    sel(4);
    chk("w4_par_flush", 128'(ifc.stack_depth), 128'(0));
    sel(2);
    chk("w2_hold", 128'(ifc.stack_depth), 128'(8));
    sel(1);
    chk("w1_hold", 128'(ifc.top_entry), 128'(ea));

    // Async reset in the middle of a warp 6 push sequence
    sel(6);
    for (int k = 0; k < 5; k++) begin
      ifc.push = 1'b1; ifc.push_entry = mk(32'h600 + 32'(k), 32'h7, 32'h3); tick();
    end
    chk("w6_depth5", 128'(ifc.stack_depth), 128'(5));
    ifc.push = 1'b1; ifc.push_entry = mk(32'h6F0, 32'h7, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_depth", 128'(ifc.stack_depth),   128'(0));
    chk("arst_empty", 128'(ifc.stack_empty),   128'(1));
    chk("arst_full",  128'(ifc.stack_full),    128'(0));
    chk("arst_top",   128'(ifc.top_entry),     128'(0));
    chk("arst_ovf",   128'(ifc.overflow_err),  128'(0));
    chk("arst_unf",   128'(ifc.underflow_err), 128'(0));
    @(posedge clk); #1;
    ifc.push = 1'b0;
    rst_n = 1'b1;
    #1;
    for (int w = 0; w < 8; w++) begin
      sel(w);
      chk($sformatf("post_rst_empty_w%0d", w), 128'(ifc.stack_empty), 128'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simt_reconv_stack.md
Name: simt_reconv_stack

Overview:
- Per-warp SIMT reconvergence stack; the responder end of the execute stage's divergence push/pop interface.
- Stores divergence contexts on push and presents the top-of-stack entry for the selected warp.
- Flags when the warp's current PC reaches the top entry's reconvergence PC.
- Sits beside the warp scheduler and context table; execute stage drives push/pop, this block answers with top entry and reconvergence status.

Parameters:
- NUM_WARPS, 8, number of independent per-warp stacks.
- STACK_DEPTH, 8, entries per warp stack (power of two, ≥2).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- warp_id  input  $clog2(NUM_WARPS)  warp addressed by push/pop and the top/status outputs.
- pc_valid  input  1  current_pc is meaningful this cycle.
- current_pc  input  ADDR_WIDTH  PC of the instruction in execute for warp_id.
- push  input  1  push push_entry onto warp_id's stack.
- push_entry  input  simt_stack_entry_t  {reconvergence_pc, active_mask, taken_mask}.
- pop  input  1  pop warp_id's top entry.
- flush_warp  input  1  clear the stack of flush_warp_id (warp exit/kill).
- flush_warp_id  input  $clog2(NUM_WARPS)  warp to clear.
- top_entry  output  simt_stack_entry_t  top of warp_id's stack; '0 when empty.
- at_reconvergence  output  1  pc_valid && !empty && current_pc == top_entry.reconvergence_pc.
- stack_empty  output  1  warp_id's depth == 0.
- stack_full  output  1  warp_id's depth == STACK_DEPTH.
- stack_depth  output  $clog2(STACK_DEPTH)+1  warp_id's entry count.
- overflow_err  output  1  sticky; a push was attempted on a full stack.
- underflow_err  output  1  sticky; a pop was attempted on an empty stack.

Behaviour:
- Reset (async, rst_n low): all per-warp depth counters 0; overflow_err and underflow_err 0. Therefore top_entry='0, at_reconvergence=0, stack_empty=1, stack_full=0, stack_depth=0. Entry storage is not reset.
- Storage: NUM_WARPS x STACK_DEPTH entry array, written on clk. Per-warp depth counter; top index = depth-1.
- Outputs are combinational from the registered state of warp_id: top_entry, status flags and at_reconvergence reflect state as of the last clock edge. A push becomes visible on top_entry one cycle later.
- Push only, not full: write entry at index depth, depth+1.
- Push only, full: entry dropped, depth unchanged, overflow_err set.
- Pop only, not empty: depth-1. Stored data is not cleared.
- Pop only, empty: ignored, underflow_err set.
- Push and pop in the same cycle, not empty: replace top. Write at depth-1, depth unchanged.
- Push and pop in the same cycle, empty: behaves as push only, underflow_err set.
- flush_warp: flush_warp_id's depth is set to 0 at the next edge. If it targets the same warp as a push/pop, flush wins. Flush of another warp proceeds in parallel with push/pop on warp_id.
- Error flags are cleared only by reset.
- Width rules: pc comparison is the full ADDR_WIDTH. Depth counter is $clog2(STACK_DEPTH)+1 bits and never wraps (saturates via the full/empty guards).
- Only warp_id's stack changes on push/pop; other warps hold their state.

Decomposition:
- pkg_opengpu: simt_stack_entry_t already exists there; add SIMT_STACK_DEPTH and SIMT_NUM_WARPS constants.
- One natural sub-module: simt_stack_bank, a single-warp stack (storage, depth counter, push/pop/flush logic) instantiated NUM_WARPS times.
- Top-level block does warp_id demux of push/pop, output mux, reconvergence compare and error flags.

Test Plan:
- Reset, then warp 0 pushes {pc=0x100, mask=0xFFFFFFFF, taken=0x0000FFFF} -> next cycle top_entry matches, stack_depth=1, stack_empty=0.
- Warp 0 depth 1, current_pc=0x100, pc_valid=1 -> at_reconvergence=1. pc_valid=0 or current_pc=0x104 -> 0. Pop -> depth 0, top_entry='0.
- Push 9 entries on warp 2 with STACK_DEPTH=8 -> stack_full=1 after 8, 9th dropped, overflow_err=1, top still 8th entry. Pop on empty warp 3 -> underflow_err=1.
- Simultaneous push+pop on warp 1 at depth 2 -> depth stays 2, top = new entry, entry 0 intact after a subsequent pop.
- Warp 4 depth 3; flush_warp for warp 4 with a same-cycle push to warp 4 -> depth 0. Same cycle push to warp 5 -> warp 5 depth 1.
- Assert rst_n low mid-push sequence at depth 5 -> all outputs at reset values immediately; after release every warp empty.
